// File: rtl/stream_transpose_pingpong_if.sv
// Row-beat streaming bus for the ping-pong transposer: input rows in, transposed rows out.
// The master drives rows in and accepts rows out; the slave is the transposer.
interface stream_transpose_pingpong_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N          = 32
);
    logic [DATA_WIDTH*N-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH*N-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/stream_transpose_pingpong.sv
// Streaming N x N transposer: rows in, columns out, two register banks alternate so
// one block fills while the other drains; a short trailing block is zero-padded.
module stream_transpose_pingpong #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N          = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    stream_transpose_pingpong_if.slave bus,
    input  logic [CNT_WIDTH-1:0]  ctx_length,
    output logic [CNT_WIDTH-1:0]  blocks_out,
    output logic                  ctx_done
);
    localparam int unsigned IW = $clog2(N);

    logic [DATA_WIDTH-1:0] bank [2][N][N];
    logic [1:0]            full;
    logic [IW:0]           nrows [2];
    logic                  wb;
    logic                  rb;
    logic [IW-1:0]         wcnt;
    logic [IW-1:0]         rcnt;
    logic [CNT_WIDTH-1:0]  rows_in;
    logic                  done_q;

    logic ctx_end;
    logic accept;
    logic close_blk;
    logic xfer;
    logic drain_blk;

    assign ctx_end      = (ctx_length != '0) && (rows_in == ctx_length);
    assign bus.in_ready = !reset && !full[wb] && !ctx_end;
    assign accept       = bus.in_valid && bus.in_ready;
    assign close_blk    = accept && ((wcnt == IW'(N-1)) ||
                          ((ctx_length != '0) && (rows_in + CNT_WIDTH'(1) == ctx_length)));

    assign bus.out_valid = !reset && full[rb];
    assign xfer          = bus.out_valid && bus.out_ready;
    assign drain_blk     = xfer && (rcnt == IW'(N-1));

    assign ctx_done = !reset && (done_q || (ctx_end && (full == '0)));

    // Output row rcnt is column rcnt of the block; rows never written read as zero.
    always_comb begin
        bus.out_data = '0;
        if (bus.out_valid) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (i < 32'(nrows[rb]))
                    bus.out_data[i*DATA_WIDTH +: DATA_WIDTH] = bank[rb][IW'(i)][rcnt];
            end
        end
    end

    // Storage is not reset: full/nrows gate every read, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned e = 0; e < N; e++)
                bank[wb][wcnt][IW'(e)] <= bus.in_data[e*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full       <= '0;
            nrows[0]   <= '0;
            nrows[1]   <= '0;
            wb         <= 1'b0;
            rb         <= 1'b0;
            wcnt       <= '0;
            rcnt       <= '0;
            rows_in    <= '0;
            blocks_out <= '0;
            done_q     <= 1'b0;
        end else begin
            if (accept) begin
                if (rows_in != '1)
                    rows_in <= rows_in + CNT_WIDTH'(1);
                if (close_blk) begin
                    full[wb]  <= 1'b1;
                    nrows[wb] <= {1'b0, wcnt} + (IW+1)'(1);
                    wb        <= ~wb;
                    wcnt      <= '0;
                end else begin
                    wcnt <= wcnt + IW'(1);
                end
            end
            // Close and drain in the same cycle always hit different banks.
            if (xfer) begin
                if (drain_blk) begin
                    full[rb]   <= 1'b0;
                    rb         <= ~rb;
                    rcnt       <= '0;
                    blocks_out <= blocks_out + CNT_WIDTH'(1);
                end else begin
                    rcnt <= rcnt + IW'(1);
                end
            end
            if (ctx_end && (full == '0))
                done_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_stream_transpose_pingpong.sv
// Self-checking bench for stream_transpose_pingpong: N=4 instance for the corner cases,
// default N=32 instance for the full-size transpose.
module tb_stream_transpose_pingpong;
    localparam int unsigned DW = 16;
    localparam int unsigned N  = 4;
    localparam int unsigned NB = 32;
    localparam int unsigned CW = 32;

    typedef logic [DW*N-1:0]  row4_t;
    typedef logic [DW*NB-1:0] row32_t;
    typedef struct {
        row4_t in_row;
        row4_t exp_row;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] ctx_length = '0;
    logic [CW-1:0] ctx32 = '0;
    logic [CW-1:0] blocks_out;
    logic [CW-1:0] blocks32;
    logic          ctx_done;
    logic          done32;

    always #5 clk = ~clk;

    stream_transpose_pingpong_if #(.DATA_WIDTH(DW), .N(N))  bus4 ();
    stream_transpose_pingpong_if #(.DATA_WIDTH(DW), .N(NB)) bus32 ();

    stream_transpose_pingpong #(.DATA_WIDTH(DW), .N(N), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus4),
        .ctx_length(ctx_length), .blocks_out(blocks_out), .ctx_done(ctx_done)
    );

    stream_transpose_pingpong dut32 (
        .clk(clk), .reset(reset), .bus(bus32),
        .ctx_length(ctx32), .blocks_out(blocks32), .ctx_done(done32)
    );

    int     checks = 0;
    int     errors = 0;
    row4_t  q4[$];
    row32_t q32[$];
    int     n_out4 = 0;
    int     n_out32 = 0;
    bit     model_on = 1'b1;
    logic [DW-1:0] blk [N][N];
    int     mrows = 0;
    int     mtotal = 0;
    time    accept_t = 0;
    time    first_valid_t = 0;
    bit     arm_lat = 1'b0;
    bit     track_gap = 1'b0;
    bit     seen_xfer = 1'b0;
    time    last_xfer_t = 0;
    int     gaps = 0;
    vec_t   vt [N];

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: collect accepted rows, on block close emit N column rows (zero beyond rows held).
    task automatic model_accept(input row4_t row);
        row4_t r;
        for (int e = 0; e < N; e++) blk[mrows][e] = row[e*DW +: DW];
        mrows++;
        mtotal++;
        if (mrows == N || (ctx_length != 0 && mtotal == int'(ctx_length))) begin
            for (int j = 0; j < N; j++) begin
                r = '0;
                for (int i = 0; i < N; i++)
                    if (i < mrows) r[i*DW +: DW] = blk[i][j];
                q4.push_back(r);
            end
            mrows = 0;
        end
    endtask

    task automatic send4(input row4_t row, input int budget, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        bus4.in_data  = row;
        bus4.in_valid = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (bus4.in_ready) begin
                @(posedge clk);
                accept_t = $time;
                ok = 1'b1;
                break;
            end
            waited++;
            @(posedge clk);
        end
        #1;
        bus4.in_valid = 1'b0;
        check("row_accepted", ok, 1'b1);
        if (ok && model_on) model_accept(row);
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #2;
            if (q4.size() == 0 && q32.size() == 0) break;
        end
        check("drain_queue_empty", q4.size() + q32.size(), 0);
    endtask

    task automatic restart(input logic [CW-1:0] ctx);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus4.in_valid = 1'b0;
        bus32.in_valid = 1'b0;
        ctx_length = ctx;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        q4.delete();
        q32.delete();
        mrows = 0;
        mtotal = 0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (arm_lat && bus4.out_valid) begin
                first_valid_t = $time;
                arm_lat = 1'b0;
            end
            if (!bus4.out_valid) check("out_data_zero_idle", bus4.out_data, '0);
            if (bus4.out_valid && bus4.out_ready) begin
                if (track_gap) begin
                    if (seen_xfer && $time != last_xfer_t + 10) gaps++;
                    seen_xfer = 1'b1;
                    last_xfer_t = $time;
                end
                if (q4.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out4_unexpected: got %0h, expected no output", bus4.out_data);
                end else begin
                    check("out4_row", bus4.out_data, q4.pop_front());
                end
                n_out4++;
            end
            if (bus32.out_valid && bus32.out_ready) begin
                if (q32.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out32_unexpected: got %0h, expected no output", bus32.out_data);
                end else begin
                    check("out32_row", bus32.out_data, q32.pop_front());
                end
                n_out32++;
            end
        end
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int     w;
        int     stalls;
        int     base;
        row4_t  r;
        row4_t  hold_exp;
        row32_t r32;
        bit     ok32;

        bus4.in_data = '0;   bus4.in_valid = 1'b0;  bus4.out_ready = 1'b0;
        bus32.in_data = '0;  bus32.in_valid = 1'b0; bus32.out_ready = 1'b0;

        for (int rr = 0; rr < N; rr++)
            for (int e = 0; e < N; e++) begin
                vt[rr].in_row[e*DW +: DW]  = 16'(16*rr + e);
                vt[rr].exp_row[e*DW +: DW] = 16'(16*e + rr);
            end

        // Reset held 3 cycles
        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready", bus4.in_ready, 1'b0);
            check("rst_out_valid", bus4.out_valid, 1'b0);
            check("rst_out_data", bus4.out_data, '0);
            check("rst_blocks_out", blocks_out, '0);
            check("rst_ctx_done", ctx_done, 1'b0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single block from the vector table, with first-output latency
        model_on = 1'b0;
        bus4.out_ready = 1'b1;
        for (int rr = 0; rr < N; rr++) q4.push_back(vt[rr].exp_row);
        for (int rr = 0; rr < N; rr++) begin
            if (rr == N-1) check("no_output_before_last_row", bus4.out_valid, 1'b0);
            send4(vt[rr].in_row, 10, w);
        end
        arm_lat = 1'b1;
        wait_drain(20);
        check("first_out_latency", first_valid_t - accept_t, 5);
        check("blocks_out_one", blocks_out, 1);
        model_on = 1'b1;

        // 12 rows back-to-back with out_ready high
        restart('0);
        track_gap = 1'b1;
        seen_xfer = 1'b0;
        gaps = 0;
        stalls = 0;
        base = n_out4;
        for (int rr = 0; rr < 12; rr++) begin
            r = {$urandom, $urandom};
            send4(r, 10, w);
            stalls += w;
        end
        wait_drain(30);
        track_gap = 1'b0;
        check("stream_no_in_stall", stalls, 0);
        check("stream_out_contiguous", gaps, 0);
        check("stream_out_count", n_out4 - base, 12);
        check("stream_blocks_out", blocks_out, 3);

        // Both banks full under backpressure
        restart('0);
        bus4.out_ready = 1'b0;
        for (int rr = 0; rr < 8; rr++) send4({$urandom, $urandom}, 10, w);
        r = {$urandom, $urandom};
        hold_exp = q4[0];
        bus4.in_data = r;
        bus4.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("full_in_ready_low", bus4.in_ready, 1'b0);
            check("hold_out_valid", bus4.out_valid, 1'b1);
            check("hold_out_data", bus4.out_data, hold_exp);
        end
        @(posedge clk);
        #1;
        bus4.out_ready = 1'b1;
        send4(r, 20, w);
        for (int rr = 0; rr < 3; rr++) send4({$urandom, $urandom}, 10, w);
        wait_drain(40);
        check("bp_blocks_out", blocks_out, 3);

        // Context of 6 rows: trailing block zero-padded, then ctx_done
        restart(32'd6);
        bus4.out_ready = 1'b0;
        for (int rr = 0; rr < 6; rr++) send4({$urandom, $urandom}, 10, w);
        bus4.in_data = {$urandom, $urandom};
        bus4.in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("ctx_end_in_ready", bus4.in_ready, 1'b0);
            check("ctx_done_before_drain", ctx_done, 1'b0);
        end
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b1;
        wait_drain(30);
        check("ctx_done_after_drain", ctx_done, 1'b1);
        check("ctx_blocks_out", blocks_out, 2);
        check("ctx_in_ready_stays_low", bus4.in_ready, 1'b0);

        // Reset in the middle of draining a block
        restart('0);
        bus4.out_ready = 1'b0;
        for (int rr = 0; rr < N; rr++) send4({$urandom, $urandom}, 10, w);
        base = n_out4;
        bus4.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (n_out4 >= base + 2) break;
        end
        check("two_beats_before_reset", n_out4 - base, 2);
        reset = 1'b1;
        q4.delete();
        mrows = 0;
        mtotal = 0;
        @(negedge clk);
        check("mid_reset_out_valid", bus4.out_valid, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("post_reset_out_valid", bus4.out_valid, 1'b0);
            check("post_reset_blocks_out", blocks_out, '0);
        end
        @(posedge clk);
        #1;
        for (int rr = 0; rr < N; rr++) send4({$urandom, $urandom}, 10, w);
        wait_drain(20);
        check("post_reset_blocks_out_one", blocks_out, 1);

        // Full-size N=32 transpose
        restart('0);
        bus32.out_ready = 1'b1;
        for (int j = 0; j < NB; j++) begin
            r32 = '0;
            for (int i = 0; i < NB; i++) r32[i*DW +: DW] = 16'(32*i + j);
            q32.push_back(r32);
        end
        for (int rr = 0; rr < NB; rr++) begin
            for (int e = 0; e < NB; e++) r32[e*DW +: DW] = 16'(32*rr + e);
            bus32.in_data = r32;
            bus32.in_valid = 1'b1;
            ok32 = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (bus32.in_ready) begin
                    @(posedge clk);
                    ok32 = 1'b1;
                    break;
                end
                @(posedge clk);
            end
            #1;
            bus32.in_valid = 1'b0;
            check("row32_accepted", ok32, 1'b1);
        end
        wait_drain(80);
        check("n32_out_count", n_out32, NB);
        check("n32_blocks_out", blocks32, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
